// File: rtl/jt12_opram_ctl.sv
// Sequencer/writer for the per-operator state RAM: clears the RAM after reset,
// then cycles the operator slots and merges queued host field writes into write-back.
module jt12_opram_ctl #(
    parameter int unsigned    SLOTS    = 24,
    parameter int unsigned    W        = 44,
    parameter logic [W-1:0]   INIT_VAL = {7'h7F, 37'd0},
    parameter int unsigned    QDEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    output logic [4:0]   ram_rd_addr,
    output logic [4:0]   ram_wr_addr,
    output logic [W-1:0] ram_data,
    input  logic [W-1:0] ram_q,
    output logic         op_valid,
    output logic [4:0]   op_slot,
    output logic [W-1:0] op_q,
    input  logic [W-1:0] op_new,
    input  logic         host_valid,
    output logic         host_ready,
    input  logic [4:0]   host_slot,
    input  logic [W-1:0] host_mask,
    input  logic [W-1:0] host_data,
    output logic         init_done
);

    localparam int unsigned QAW       = $clog2(QDEPTH);
    localparam int unsigned CW        = QAW + 1;
    localparam logic [4:0]  LAST_SLOT = 5'(SLOTS - 1);
    localparam logic [4:0]  LAST_ADDR = 5'd31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      init_cnt_q, init_cnt_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      op_slot_q, op_slot_d;
    logic            op_valid_q, op_valid_d;
    logic            init_done_q, init_done_d;

    logic [4:0]      q_slot_q [QDEPTH];
    logic [W-1:0]    q_mask_q [QDEPTH];
    logic [W-1:0]    q_data_q [QDEPTH];
    logic [4:0]      q_slot_d [QDEPTH];
    logic [W-1:0]    q_mask_d [QDEPTH];
    logic [W-1:0]    q_data_d [QDEPTH];
    logic [QAW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QAW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            q_full;
    logic            q_empty;
    logic            push;
    logic            pop;
    logic            head_hit;
    logic [4:0]      head_slot;
    logic [W-1:0]    head_mask;
    logic [W-1:0]    head_data;
    logic [W-1:0]    merged;

    assign q_full     = (count_q == CW'(QDEPTH));
    assign q_empty    = (count_q == '0);
    assign host_ready = !q_full && rst_n;
    assign push       = host_valid && host_ready;

    assign head_slot  = q_slot_q[rd_ptr_q];
    assign head_mask  = q_mask_q[rd_ptr_q];
    assign head_data  = q_data_q[rd_ptr_q];
    // op_slot never exceeds SLOTS-1, so an out-of-range head can never hit.
    assign head_hit   = !q_empty && (head_slot == op_slot_q);
    assign merged     = (op_new & ~head_mask) | (head_data & head_mask);

    assign op_valid   = op_valid_q;
    assign op_slot    = op_slot_q;
    assign op_q       = ram_q;
    assign init_done  = init_done_q;

    // Sequencer: next state and RAM port drive.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        cnt_d       = cnt_q;
        op_slot_d   = op_slot_q;
        op_valid_d  = op_valid_q;
        init_done_d = init_done_q;
        ram_rd_addr = '0;
        ram_wr_addr = init_cnt_q;
        ram_data    = INIT_VAL;
        pop         = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (clk_en) begin
                    init_cnt_d = init_cnt_q + 5'd1;
                    if (init_cnt_q == LAST_ADDR) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                ram_rd_addr = cnt_q;
                // Before the first slot is live the counter has wrapped to 0,
                // so the idle write just rewrites INIT_VAL into word 0.
                if (op_valid_q) begin
                    ram_wr_addr = op_slot_q;
                    ram_data    = head_hit ? merged : op_new;
                end
                if (clk_en) begin
                    cnt_d      = (cnt_q == LAST_SLOT) ? 5'd0 : cnt_q + 5'd1;
                    op_slot_d  = cnt_q;
                    op_valid_d = 1'b1;
                    pop        = op_valid_q && head_hit;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Host write queue: push on any edge, pop only on a matching write-back.
    always_comb begin
        q_slot_d = q_slot_q;
        q_mask_d = q_mask_q;
        q_data_d = q_data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            q_slot_d[wr_ptr_q] = host_slot;
            q_mask_d[wr_ptr_q] = host_mask;
            q_data_d[wr_ptr_q] = host_data;
            wr_ptr_d           = wr_ptr_q + QAW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + QAW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            cnt_q       <= '0;
            op_slot_q   <= '0;
            op_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cnt_q       <= cnt_d;
            op_slot_q   <= op_slot_d;
            op_valid_q  <= op_valid_d;
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        q_slot_q <= q_slot_d;
        q_mask_q <= q_mask_d;
        q_data_q <= q_data_d;
    end

endmodule

// File: tb/tb_jt12_opram_ctl.sv
// Directed bench for jt12_opram_ctl with a behavioural 32-word RAM and an
// increment-by-one operator looped back through op_new.
module tb_jt12_opram_ctl;

    localparam int              SLOTS    = 24;
    localparam int              W        = 44;
    localparam logic [W-1:0]    INIT_VAL = {7'h7F, 37'd0};

    typedef struct {
        logic [4:0]   slot;
        logic [W-1:0] mask;
        logic [W-1:0] data;
    } hw_t;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic [4:0]   ram_rd_addr;
    logic [4:0]   ram_wr_addr;
    logic [W-1:0] ram_data;
    logic [W-1:0] ram_q;
    logic         op_valid;
    logic [4:0]   op_slot;
    logic [W-1:0] op_q;
    logic [W-1:0] op_new;
    logic         host_valid;
    logic         host_ready;
    logic [4:0]   host_slot;
    logic [W-1:0] host_mask;
    logic [W-1:0] host_data;
    logic         init_done;

    logic [W-1:0] mem [32];
    logic [W-1:0] exp_word [32];
    hw_t          exp_q [$];
    int           exp_slot;
    int           total;
    int           bad;

    jt12_opram_ctl #(
        .SLOTS(SLOTS), .W(W), .INIT_VAL(INIT_VAL), .QDEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
        .ram_data(ram_data), .ram_q(ram_q),
        .op_valid(op_valid), .op_slot(op_slot), .op_q(op_q), .op_new(op_new),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_slot(host_slot), .host_mask(host_mask), .host_data(host_data),
        .init_done(init_done)
    );

    // Clock and RAM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (clk_en) begin
            mem[ram_wr_addr] <= ram_data;
            ram_q            <= mem[ram_rd_addr];
        end
    end

    assign op_new = op_q + 44'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] s, input logic [W-1:0] m,
                        input logic [W-1:0] d, input bit accept);
        hw_t e;
        clk_en     = 1'b0;
        host_valid = 1'b1;
        host_slot  = s;
        host_mask  = m;
        host_data  = d;
        chk("host_ready_at_push", host_ready, accept);
        step();
        host_valid = 1'b0;
        if (accept) begin
            e.slot = s;
            e.mask = m;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic init_sweep();
        int errs;
        clk_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                clk_en = 1'b0;
                step();
                step();
                chk("init_hold_addr", ram_wr_addr, 10);
                clk_en = 1'b1;
            end
            chk("init_wr_addr", ram_wr_addr, i);
            chk("init_wr_data", ram_data, INIT_VAL);
            chk("init_done_low", init_done, 0);
            chk("init_op_valid", op_valid, 0);
            step();
        end
        chk("init_done_high", init_done, 1);
        chk("run_op_valid_first", op_valid, 0);
        chk("run_rd_addr_first", ram_rd_addr, 0);
        errs = 0;
        for (int k = 0; k < 32; k++) begin
            if (mem[k] !== INIT_VAL) errs++;
            exp_word[k] = INIT_VAL;
        end
        chk("init_mem_words_bad", errs, 0);
        step();
        exp_slot = 0;
    endtask

    task automatic run_tick();
        logic [W-1:0] exp_data;
        clk_en = 1'b1;
        chk("op_valid", op_valid, 1);
        chk("op_slot", op_slot, exp_slot);
        chk("op_q", op_q, exp_word[exp_slot]);
        chk("ram_wr_addr", ram_wr_addr, exp_slot);
        chk("ram_rd_addr", ram_rd_addr, (exp_slot + 1) % SLOTS);
        exp_data = exp_word[exp_slot] + 44'd1;
        if (exp_q.size() > 0 && int'(exp_q[0].slot) == exp_slot) begin
            exp_data = (exp_data & ~exp_q[0].mask) | (exp_q[0].data & exp_q[0].mask);
            void'(exp_q.pop_front());
        end
        chk("ram_data", ram_data, exp_data);
        exp_word[exp_slot] = exp_data;
        step();
        exp_slot = (exp_slot + 1) % SLOTS;
    endtask

    initial begin
        logic [W-1:0] w5;
        total      = 0;
        bad        = 0;
        exp_slot   = 0;
        rst_n      = 1'b0;
        clk_en     = 1'b0;
        host_valid = 1'b0;
        host_slot  = '0;
        host_mask  = '0;
        host_data  = '0;

        // Reset with clk_en low still takes effect
        step();
        step();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_slot", op_slot, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_wr_addr", ram_wr_addr, 0);
        chk("rst_wr_data", ram_data, INIT_VAL);
        chk("rst_rd_addr", ram_rd_addr, 0);
        rst_n = 1'b1;
        #1;
        chk("host_ready_after_rst", host_ready, 1);

        init_sweep();

        // Plain running: two full revolutions plus one
        for (int i = 0; i < 2 * SLOTS + 1; i++) run_tick();

        // Single field write to slot 5
        push(5'd5, 44'h00F_0000_0000, 44'hFFF_FFFF_FFFF, 1'b1);
        for (int i = 0; i < SLOTS + 2; i++) run_tick();
        w5 = mem[5];
        chk("slot5_field", w5[35:32], 4'hF);

        // Fill the queue with clk_en low
        push(5'd10, 44'h000_0000_00FF, 44'h000_0000_00A5, 1'b1);
        push(5'd12, 44'hFFF_0000_0000, 44'h123_0000_0000, 1'b1);
        push(5'd1,  44'h000_0000_FF00, 44'h000_0000_3C00, 1'b1);
        push(5'd20, 44'h7FF_FFFF_FFFF, 44'h000_0000_0000, 1'b1);
        chk("host_ready_full", host_ready, 0);
        push(5'd7,  44'hFFF_FFFF_FFFF, 44'h555_5555_5555, 1'b0);
        chk("hold_op_slot", op_slot, exp_slot);
        chk("hold_wr_addr", ram_wr_addr, exp_slot);
        for (int i = 0; i < 2 * SLOTS; i++) run_tick();
        chk("host_ready_drained", host_ready, 1);

        // Two writes to slot 3 apply one revolution apart
        push(5'd3, 44'h000_0000_000F, 44'h000_0000_0005, 1'b1);
        push(5'd3, 44'h000_0000_00F0, 44'h000_0000_0070, 1'b1);
        for (int i = 0; i < 2 * SLOTS + 2; i++) run_tick();

        // Reset mid-run discards queued writes
        push(5'd15, 44'hFFF_FFFF_FFFF, 44'hABC_DEF0_1234, 1'b1);
        push(5'd16, 44'hFFF_FFFF_FFFF, 44'h111_2222_3333, 1'b1);
        rst_n  = 1'b0;
        clk_en = 1'b0;
        #1;
        chk("midrst_host_ready", host_ready, 0);
        step();
        chk("midrst_op_valid", op_valid, 0);
        chk("midrst_init_done", init_done, 0);
        chk("midrst_wr_addr", ram_wr_addr, 0);
        rst_n = 1'b1;
        exp_q.delete();
        init_sweep();
        for (int i = 0; i < SLOTS + 2; i++) run_tick();
        chk("post_rst_host_ready", host_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
